var_delay_line: RTL and testbench

- Runtime-programmable, sample-indexed delay line, implemented as a circular buffer with independent write and read pointers.
- Companion to the fixed cycle-count delay: it aligns sample streams whose relative skew is known only at run time, e.g. audio vs. video pipeline latency after a scaler mode change.
- Sits between a sample producer (valid-qualified) and the downstream mixer/formatter.

---
 rtl/var_delay_pkg.sv | 13 +
 rtl/var_delay_line_sdp_ram.sv | 21 ++
 rtl/var_delay_line.sv | 79 +++++++
 tb/tb_var_delay_line.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/var_delay_pkg.sv
// var_delay_pkg: shared FSM state type, delay limit and clamp helper for var_delay_line
package var_delay_pkg;

    typedef enum logic [0:0] {FILL, RUN} state_t;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam logic [31:0] MAX_DELAY = 32'(2**DEF_ADDR_WIDTH - 1);

    function automatic logic [31:0] clamp_delay(input logic [31:0] d, input logic [31:0] max_d);
        return (d > max_d) ? max_d : d;
    endfunction

endpackage

// File: rtl/var_delay_line_sdp_ram.sv
// sdp_ram: simple dual-port RAM, one synchronous write port, one asynchronous read port
module sdp_ram #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/var_delay_line.sv
// var_delay_line: runtime-programmable sample-count delay line over a circular buffer
module var_delay_line
    import var_delay_pkg::*;
#(
    parameter int DATA_WIDTH    = 12,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DEFAULT_DELAY = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_load,
    input  logic [ADDR_WIDTH-1:0]        delay_cfg,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         busy,
    output logic [ADDR_WIDTH-1:0]        cur_delay
);

    localparam logic [31:0]           MAXD      = 32'(2**ADDR_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] DEF_D     = ADDR_WIDTH'(DEFAULT_DELAY);
    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);
    localparam state_t                RST_STATE = (DEFAULT_DELAY == 0) ? RUN : FILL;

    state_t                  state, eff_state;
    logic [ADDR_WIDTH-1:0]   wr_ptr, fill_cnt, new_delay, eff_delay, eff_fill, rd_addr;
    logic [DATA_WIDTH-1:0]   rd_data;

    // A load takes effect on the sample arriving in the same cycle
    always_comb begin
        new_delay = ADDR_WIDTH'(clamp_delay(32'(delay_cfg), MAXD));
        eff_delay = cfg_load ? new_delay : cur_delay;
        eff_fill  = cfg_load ? '0 : fill_cnt;
        eff_state = cfg_load ? ((new_delay == '0) ? RUN : FILL) : state;
        rd_addr   = wr_ptr - cur_delay;
    end

    sdp_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (in_valid),
        .waddr(wr_ptr),
        .wdata(data_in),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RST_STATE;
            cur_delay <= DEF_D;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            cur_delay <= eff_delay;
            out_valid <= in_valid;
            state     <= eff_state;
            fill_cnt  <= eff_fill;
            if (in_valid) begin
                wr_ptr   <= wr_ptr + ONE;
                // zero delay bypasses the RAM since its read precedes the write
                data_out <= (eff_state == FILL) ? '0 :
                            (eff_delay == '0) ? data_in : $signed(rd_data);
                if (eff_state == FILL) begin
                    state    <= (eff_fill == eff_delay - ONE) ? RUN : FILL;
                    fill_cnt <= (&eff_fill) ? eff_fill : eff_fill + ONE;
                end
            end
        end
    end

    assign busy = (state == FILL);

endmodule

// File: tb/tb_var_delay_line.sv
// tb_var_delay_line: directed self-checking bench for var_delay_line (8-bit and 4-bit address builds)
module tb_var_delay_line;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_load, in_valid;
    logic [7:0]         delay_cfg;
    logic signed [11:0] data_in, data_out;
    logic               out_valid, busy;
    logic [7:0]         cur_delay;

    logic               s_cfg_load, s_in_valid;
    logic [3:0]         s_delay_cfg;
    logic signed [11:0] s_data_in, s_data_out;
    logic               s_out_valid, s_busy;
    logic [3:0]         s_cur_delay;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    var_delay_line u_dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .delay_cfg(delay_cfg),
        .in_valid(in_valid), .data_in(data_in), .out_valid(out_valid),
        .data_out(data_out), .busy(busy), .cur_delay(cur_delay)
    );

    var_delay_line #(.ADDR_WIDTH(4)) u_small (
        .clk(clk), .rst(rst), .cfg_load(s_cfg_load), .delay_cfg(s_delay_cfg),
        .in_valid(s_in_valid), .data_in(s_data_in), .out_valid(s_out_valid),
        .data_out(s_data_out), .busy(s_busy), .cur_delay(s_cur_delay)
    );

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; cfg_load = 0; delay_cfg = 0; in_valid = 0; data_in = 0;
        s_cfg_load = 0; s_delay_cfg = 0; s_in_valid = 0; s_data_in = 0;
        #2;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_data_out", 32'(data_out), 0);
        check("rst_cur_delay", 32'(cur_delay), 8);
        check("rst_busy", 32'(busy), 1);
        step();
        step();
        rst = 1'b0;

        // default delay 8, continuous input 1,2,3...
        for (int n = 1; n <= 12; n++) begin
            in_valid = 1; data_in = 12'(n);
            step();
            check("cont_valid", 32'(out_valid), 1);
            check("cont_data", 32'(data_out), (n <= 8) ? 0 : n - 8);
            check("cont_busy", 32'(busy), (n < 8) ? 1 : 0);
        end
        in_valid = 0;

        // gapped input, delay 4
        cfg_load = 1; delay_cfg = 4;
        step();
        cfg_load = 0;
        check("gap_cur_delay", 32'(cur_delay), 4);
        check("gap_busy", 32'(busy), 1);
        for (int k = 0; k < 8; k++) begin
            in_valid = 1; data_in = 12'(-5 + k);
            step();
            in_valid = 0;
            check("gap_valid", 32'(out_valid), 1);
            check("gap_data", 32'(data_out), (k < 4) ? 0 : -5 + k - 4);
            step();
            check("gap_idle_valid", 32'(out_valid), 0);
            check("gap_hold", 32'(data_out), (k < 4) ? 0 : -5 + k - 4);
            step();
        end

        // load delay 0 with a sample in the same cycle: passthrough
        cfg_load = 1; delay_cfg = 0; in_valid = 1; data_in = 12'h7FF;
        step();
        cfg_load = 0;
        check("zero_data", 32'(data_out), 32'sh7FF);
        check("zero_valid", 32'(out_valid), 1);
        check("zero_busy", 32'(busy), 0);
        check("zero_cur_delay", 32'(cur_delay), 0);
        data_in = 12'sh123;
        step();
        check("zero_pass", 32'(data_out), 32'sh123);
        in_valid = 0;

        // delay 3 running, then load 2 together with a sample
        cfg_load = 1; delay_cfg = 3;
        step();
        cfg_load = 0;
        for (int n = 0; n < 6; n++) begin
            in_valid = 1; data_in = 12'(100 + n);
            step();
        end
        check("d3_run", 32'(data_out), 102);
        cfg_load = 1; delay_cfg = 2; data_in = 200;
        step();
        cfg_load = 0;
        check("ld_same_data", 32'(data_out), 0);
        check("ld_same_busy", 32'(busy), 1);
        check("ld_same_cnt", 32'(cur_delay), 2);
        data_in = 201;
        step();
        check("ld_next_data", 32'(data_out), 0);
        check("ld_next_busy", 32'(busy), 0);
        data_in = 202;
        step();
        check("ld_third_data", 32'(data_out), 200);
        data_in = 203;
        step();
        check("ld_fourth_data", 32'(data_out), 201);
        check("ld_valid_before_rst", 32'(out_valid), 1);

        // asynchronous reset mid-stream
        in_valid = 0;
        rst = 1'b1;
        #1;
        check("arst_data", 32'(data_out), 0);
        check("arst_valid", 32'(out_valid), 0);
        check("arst_busy", 32'(busy), 1);
        check("arst_cur_delay", 32'(cur_delay), 8);
        step();
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            in_valid = 1; data_in = 12'(50 + n);
            step();
            check("post_rst_data", 32'(data_out), (n < 8) ? 0 : 50 + n - 8);
        end
        in_valid = 0;

        // 4-bit build: maximum delay and pointer wrap
        s_cfg_load = 1; s_delay_cfg = 4'hF;
        step();
        s_cfg_load = 0;
        check("max_cur_delay", 32'(s_cur_delay), 15);
        check("max_busy", 32'(s_busy), 1);
        for (int n = 0; n < 40; n++) begin
            s_in_valid = 1; s_data_in = 12'(3 * n - 7);
            step();
            check("wrap_data", 32'(s_data_out), (n < 15) ? 0 : 3 * (n - 15) - 7);
        end
        check("wrap_busy", 32'(s_busy), 0);
        s_in_valid = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
